// File: rtl/uart_rx_if.sv
// Receiver-side bundle between the RX pin, the uart_rx core and its consumer.
// The consumer (master) drives the line and clr_rdy; uart_rx (slave) returns the byte and flags.
interface uart_rx_if;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  modport master (
    output RX,
    output clr_rdy,
    input  rx_data,
    input  rdy,
    input  frm_err
  );

  modport slave (
    input  RX,
    input  clr_rdy,
    output rx_data,
    output rdy,
    output frm_err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronized RX, mid-bit sampling, sticky rdy/frm_err
// that the consumer clears with clr_rdy.
module uart_rx #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned HALF_DIV = BAUD_DIV / 2
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Counter acts on the cycle it reads zero, so a load of N spans N+1 clocks.
  // The start load also absorbs the two synchronizer stages and the detect cycle,
  // putting every sample at the bit centre of the pin itself.
  localparam logic [11:0] HALF_LOAD = 12'(HALF_DIV - 2);
  localparam logic [11:0] BAUD_LOAD = 12'(BAUD_DIV - 1);

  logic        rx_meta_r;
  logic        rx_s_r;
  state_t      state_r,   state_nxt_s;
  logic [11:0] cnt_r,     cnt_nxt_s;
  logic [3:0]  bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0]  shift_r,   shift_nxt_s;
  logic [7:0]  data_r,    data_nxt_s;
  logic        rdy_r,     rdy_nxt_s;
  logic        frm_err_r, frm_err_nxt_s;
  logic        cnt_zero_s;
  logic        done_s;
  logic        start_det_s;

  assign cnt_zero_s  = (cnt_r == 12'd0);
  assign bus.rx_data = data_r;
  assign bus.rdy     = rdy_r;
  assign bus.frm_err = frm_err_r;

  // Two-flop synchronizer; preset high so reset exit never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_s_r    <= 1'b1;
    end else begin
      rx_meta_r <= bus.RX;
      rx_s_r    <= rx_meta_r;
    end
  end

  // Frame sequencing: baud counter, bit counter, shift register and completion strobes.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shift_nxt_s   = shift_r;
    data_nxt_s    = data_r;
    done_s        = 1'b0;
    start_det_s   = 1'b0;

    case (state_r)
      IDLE: begin
        if (!rx_s_r) begin
          cnt_nxt_s   = HALF_LOAD;
          start_det_s = 1'b1;
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      START: begin
        if (!cnt_zero_s) begin
          cnt_nxt_s = cnt_r - 12'd1;
        end else if (rx_s_r) begin
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s     = BAUD_LOAD;
          bit_cnt_nxt_s = 4'd0;
          state_nxt_s   = DATA;
        end
      end

      DATA: begin
        if (!cnt_zero_s) begin
          cnt_nxt_s = cnt_r - 12'd1;
        end else begin
          shift_nxt_s   = {rx_s_r, shift_r[7:1]};
          bit_cnt_nxt_s = bit_cnt_r + 4'd1;
          cnt_nxt_s     = BAUD_LOAD;
          if (bit_cnt_r == 4'd7) begin
            state_nxt_s = STOP;
          end else begin
            state_nxt_s = DATA;
          end
        end
      end

      STOP: begin
        if (!cnt_zero_s) begin
          cnt_nxt_s = cnt_r - 12'd1;
        end else begin
          data_nxt_s  = shift_r;
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end
      end

      default: begin
        cnt_nxt_s   = 12'd0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Flag update: completion outranks clearing, so a clr_rdy on the finishing cycle is lost.
  always_comb begin
    rdy_nxt_s     = rdy_r;
    frm_err_nxt_s = frm_err_r;
    if (done_s) begin
      rdy_nxt_s     = 1'b1;
      frm_err_nxt_s = ~rx_s_r;
    end else if (bus.clr_rdy || start_det_s) begin
      rdy_nxt_s     = 1'b0;
      frm_err_nxt_s = 1'b0;
    end else begin
      rdy_nxt_s     = rdy_r;
      frm_err_nxt_s = frm_err_r;
    end
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= 12'd0;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'h00;
      data_r    <= 8'h00;
      rdy_r     <= 1'b0;
      frm_err_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      shift_r   <= shift_nxt_s;
      data_r    <= data_nxt_s;
      rdy_r     <= rdy_nxt_s;
      frm_err_r <= frm_err_nxt_s;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a shortened bit period; the bench itself plays the
// transmitter and drives frames, glitches, framing errors and mid-frame reset.
module tb_uart_rx;
  localparam int B   = 32;
  localparam int H   = 16;
  localparam int LAT = 2 + H + 9 * B;   // 306 clocks from start edge to rdy

  logic clk;
  logic rst_n;
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   total_cnt = 0;
  int   cycle_cnt = 0;
  int   start_cyc = 0;
  int   rise_cyc  = 0;
  int   lat;
  logic rdy_q     = 1'b0;
  logic [7:0] pat;

  uart_rx_if bus ();

  uart_rx #(.BAUD_DIV(B), .HALF_DIV(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // rdy rising-edge timestamp, sampled away from the active edge
  always @(negedge clk) begin
    rdy_q <= bus.rdy;
    if (bus.rdy && !rdy_q) rise_cyc <= cycle_cnt;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // start bit plus 8 data bits, LSB first; leaves the caller at the start of the stop bit
  task automatic drive_data(input logic [7:0] d);
    bus.RX    = 1'b0;
    start_cyc = cycle_cnt;
    tick(B);
    for (int i = 0; i < 8; i++) begin
      bus.RX = d[i];
      tick(B);
    end
  endtask

  task automatic send_frame(input logic [7:0] d);
    drive_data(d);
    bus.RX = 1'b1;
    tick(B);
  endtask

  task automatic pulse_clr();
    bus.clr_rdy = 1'b1;
    tick(1);
    bus.clr_rdy = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.RX      = 1'b1;
    bus.clr_rdy = 1'b0;
    tick(3);
    check("reset_rdy", {31'd0, bus.rdy}, 32'd0);
    check("reset_frm_err", {31'd0, bus.frm_err}, 32'd0);
    check("reset_rx_data", {24'd0, bus.rx_data}, 32'h00);
    rst_n = 1'b1;
    tick(5);
    check("idle_no_rdy", {31'd0, bus.rdy}, 32'd0);

    // single frame, latency from start edge
    send_frame(8'hAA);
    lat = rise_cyc - start_cyc;
    check("latency_window", {31'd0, (lat >= LAT - 2) && (lat <= LAT + 2)}, 32'd1);
    check("aa_rdy", {31'd0, bus.rdy}, 32'd1);
    check("aa_data", {24'd0, bus.rx_data}, 32'hAA);
    check("aa_frm_err", {31'd0, bus.frm_err}, 32'd0);

    // back-to-back with clr_rdy between frames
    send_frame(8'h55);
    check("b2b1_data", {24'd0, bus.rx_data}, 32'h55);
    check("b2b1_rdy", {31'd0, bus.rdy}, 32'd1);
    fork
      send_frame(8'h69);
      begin
        pulse_clr();
        check("b2b_clr_rdy", {31'd0, bus.rdy}, 32'd0);
      end
    join
    check("b2b2_rdy", {31'd0, bus.rdy}, 32'd1);
    check("b2b2_data", {24'd0, bus.rx_data}, 32'h69);

    // back-to-back without clr_rdy: new start clears rdy, data held until completion
    send_frame(8'h55);
    check("b2b3_data", {24'd0, bus.rx_data}, 32'h55);
    fork
      send_frame(8'h69);
      begin
        tick(4);
        check("start_clears_rdy", {31'd0, bus.rdy}, 32'd0);
        check("data_held_in_rx", {24'd0, bus.rx_data}, 32'h55);
      end
    join
    check("b2b4_rdy", {31'd0, bus.rdy}, 32'd1);
    check("b2b4_data", {24'd0, bus.rx_data}, 32'h69);

    // clr_rdy alone, then a short glitch rejected
    pulse_clr();
    check("clr_rdy_clears", {31'd0, bus.rdy}, 32'd0);
    bus.RX = 1'b0;
    tick(8);
    bus.RX = 1'b1;
    tick(H + 2 - 8);
    check("glitch_no_rdy", {31'd0, bus.rdy}, 32'd0);
    check("glitch_data_kept", {24'd0, bus.rx_data}, 32'h69);
    send_frame(8'h3C);
    check("post_glitch_rdy", {31'd0, bus.rdy}, 32'd1);
    check("post_glitch_data", {24'd0, bus.rx_data}, 32'h3C);

    // framing error: stop bit held low
    drive_data(8'hF0);
    bus.RX = 1'b0;
    tick(H + 2);
    check("frm_rdy", {31'd0, bus.rdy}, 32'd1);
    check("frm_err_set", {31'd0, bus.frm_err}, 32'd1);
    check("frm_data", {24'd0, bus.rx_data}, 32'hF0);
    pulse_clr();
    check("frm_clr_rdy", {31'd0, bus.rdy}, 32'd0);
    check("frm_clr_err", {31'd0, bus.frm_err}, 32'd0);
    bus.RX = 1'b1;
    tick(3 * B);

    // clr_rdy on the completion cycle loses to completion
    drive_data(8'h81);
    bus.RX = 1'b1;
    tick(H + 1);
    bus.clr_rdy = 1'b1;
    tick(1);
    bus.clr_rdy = 1'b0;
    check("simul_rdy_kept", {31'd0, bus.rdy}, 32'd1);
    check("simul_data", {24'd0, bus.rx_data}, 32'h81);
    check("simul_frm_err", {31'd0, bus.frm_err}, 32'd0);
    tick(B - H - 2);
    pulse_clr();
    check("simul_later_clr", {31'd0, bus.rdy}, 32'd0);

    // reset asserted in data bit 4 of 8'hC3, released in bit 6
    pat    = 8'hC3;
    bus.RX = 1'b0;
    tick(B);
    for (int i = 0; i < 4; i++) begin
      bus.RX = pat[i];
      tick(B);
    end
    bus.RX = pat[4];
    tick(B / 2);
    rst_n = 1'b0;
    #1;
    check("midrst_rdy", {31'd0, bus.rdy}, 32'd0);
    check("midrst_data", {24'd0, bus.rx_data}, 32'h00);
    tick(B / 2);
    bus.RX = pat[5];
    tick(B);
    bus.RX = pat[6];
    tick(B / 2);
    rst_n = 1'b1;
    tick(B / 2);
    bus.RX = pat[7];
    tick(B);
    bus.RX = 1'b1;
    tick(5 * B);
    check("midrst_no_rdy", {31'd0, bus.rdy}, 32'd0);
    check("midrst_data_kept", {24'd0, bus.rx_data}, 32'h00);
    send_frame(8'h5A);
    check("after_rst_rdy", {31'd0, bus.rdy}, 32'd1);
    check("after_rst_data", {24'd0, bus.rx_data}, 32'h5A);
    check("after_rst_frm", {31'd0, bus.frm_err}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for 8N1 UART frames: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high), idle high.
- Pairs with UART_tx, with matching baud timing, so the two form a loopback-testable link.
- Sits between the external RX pin and the command-processing logic. It presents each received byte with a sticky ready flag, which the consumer clears.

Parameters:
BAUD_DIV, 2604, clocks per bit period (50 MHz / 19200 baud)
HALF_DIV, 1302, clocks from start-bit detection to the start-bit mid-point sample (BAUD_DIV/2)

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
RX  input  1  asynchronous serial input, idle high
clr_rdy  input  1  single-cycle pulse from consumer; clears rdy and frm_err
rx_data  output  8  last received byte, valid while rdy is high
rdy  output  1  byte available; sticky until cleared
frm_err  output  1  last frame had stop bit sampled low; qualifies rdy

Behaviour:
- Reset (async, rst_n low):
  - rx_data=8'h00, rdy=0, frm_err=0, state=IDLE.
  - Both RX synchronizer flops preset to 1, so no false start is seen on exit from reset.
  - Reset mid-frame aborts the frame; no partial byte is ever delivered.
- Synchronization:
  - RX passes through a two-flop synchronizer. All decisions use the second flop (rx_s).
- State machine: IDLE, START, DATA, STOP.
  - IDLE:
    - rx_s==0 -> load baud counter with HALF_DIV, go START.
    - Detection in IDLE also clears rdy and frm_err (a new frame is starting).
  - START:
    - Counter decrements each clk. At 0, sample rx_s.
    - rx_s==1 -> glitch: return to IDLE, with no rdy and no change to rx_data.
    - rx_s==0 -> load counter with BAUD_DIV, bit_cnt=0, go DATA.
  - DATA:
    - At counter 0, shift rx_s into the MSB of an 8-bit shift register (right shift, so LSB-first arrival ends LSB-aligned).
    - bit_cnt++ and reload BAUD_DIV.
    - After the 8th sample, go STOP.
  - STOP:
    - At counter 0, sample the stop bit.
    - rx_data <= shift register, rdy <= 1, frm_err <= ~rx_s. Go IDLE on the same edge.
    - The data byte is delivered even on a framing error.
- Sampling points: every sample lands at bit mid-point ±1 clk relative to the RX pin edge.
- Latency:
  - rdy rises 2 + HALF_DIV + 9*BAUD_DIV clocks (24740 nominal, ±2 tolerance) after the RX falling edge of the start bit.
  - Since the stop bit is sampled mid-bit, a back-to-back next start bit follows ≥BAUD_DIV/2 clocks later and is always caught.
- rdy/frm_err priority, highest first:
  1. reset
  2. frame completion (set)
  3. clr_rdy or new start detection (clear)
  - clr_rdy in the same cycle as completion: rdy stays 1.
  - clr_rdy while rdy=0: no effect.
- rx_data holds its value until the next completed frame. It does not change during reception.
- Counters:
  - Baud counter is 12 bits, counting down with load on zero; it never wraps negative.
  - bit_cnt is 4 bits.
  - No counter runs in IDLE.
- RX activity while in DATA/STOP never restarts the frame. Only the timing-driven samples matter.

Test Plan:
- Loopback with UART_tx: transmit 8'hAA -> rdy rises 24740±2 clks after the start edge; rx_data=8'hAA, frm_err=0.
- Back-to-back frames, with trmt re-asserted immediately on tx_done: 8'h55 then 8'h69 -> two rdy assertions (clr_rdy pulsed between them); rx_data=8'h55 then 8'h69, no byte lost. Repeat with clr_rdy never pulsed -> rdy still clears at the second start and sets at its completion.
- Glitch: RX driven low for 500 clks then high from idle -> no rdy, rx_data unchanged, FSM back in IDLE by clk 1304 after the edge; a following valid frame 8'h3C is received correctly.
- Framing error: bench drives a frame with data 8'hF0 and stop bit low -> rdy=1, frm_err=1, rx_data=8'hF0; clr_rdy pulse -> both go 0 on the next clk.
- Simultaneous clr_rdy and completion: pulse clr_rdy on the exact completion cycle of 8'h81 -> rdy=1 after the edge; a subsequent clr_rdy clears it.
- Reset mid-frame: assert rst_n low during data bit 4 of 8'hC3 -> rdy=0, rx_data=8'h00 immediately; after release, the remaining line activity produces no rdy until a fresh start edge; the next frame 8'h5A is received correctly.
